// File: rtl/mem_pkg.sv
// mem_pkg: shared types, constants and request classification for the data memory responder.
package mem_pkg;
    localparam int WORD_W = 32;
    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_ALIGN, ERR_RANGE, ERR_CONFLICT} err_cause_t;
    function automatic err_cause_t classify(input logic rd, input logic wr, input logic [1:0] lsb, input logic oor);
        return (rd && wr) ? ERR_CONFLICT : (lsb != 2'b00) ? ERR_ALIGN : oor ? ERR_RANGE : ERR_NONE;
    endfunction
endpackage

// File: rtl/data_mem_responder_ram.sv
// data_ram: single-port word RAM with synchronous write and combinational read.
module data_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= din;
    end
    assign dout = mem[idx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time load/store responder with wait states and illegal-request flagging.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);
    localparam int IW = $clog2(DEPTH);
    state_t state_q, state_d;
    err_cause_t cause_q, cause_d;
    logic [3:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-3:0] word;
    logic [WORD_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, ram_dout;
    logic wr_q, wr_d, ready_q, ready_d, busy_q, busy_d, err_q, err_d;
    logic accept, done_entry, legal, we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cause_q <= ERR_NONE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            cause_q <= cause_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        accept  = (state_q == IDLE) && (mem_read || mem_write);
        state_d = (state_q == IDLE) ? (accept ? ((WAIT_CYCLES > 0) ? WAIT : DONE) : IDLE) :
                  (state_q == WAIT) ? ((cnt_q == 4'd1) ? DONE : WAIT) : IDLE;
        cnt_d   = accept ? 4'(WAIT_CYCLES) : (state_q == WAIT) ? cnt_q - 4'd1 : cnt_q;
    end

    // With zero wait states the accept edge is also the completion edge, so
    // the datapath works on the about-to-be-latched request values.
    always_comb begin
        addr_d  = accept ? addr : addr_q;
        wdata_d = accept ? wdata : wdata_q;
        wr_d    = accept ? mem_write : wr_q;
        word    = addr_d[ADDR_W-1:2];
        cause_d = accept ? classify(mem_read, mem_write, addr[1:0], word >= (ADDR_W-2)'(DEPTH)) : cause_q;
    end

    always_comb begin
        done_entry = (state_d == DONE);
        legal      = (cause_d == ERR_NONE);
        ready_d    = done_entry;
        busy_d     = (state_d != IDLE);
        err_d      = done_entry && !legal;
        we         = !rst && done_entry && wr_d && legal;
        rdata_d    = (done_entry && !wr_d) ? (legal ? ram_dout : '0) : rdata_q;
    end

    data_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk  (clk),
        .we   (we),
        .idx  (word[IW-1:0]),
        .din  (wdata_d),
        .dout (ram_dout)
    );

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven and randomized checks on a 2-wait-state and a 0-wait-state responder.
module tb_data_mem_responder;
    import mem_pkg::*;
    localparam int DEPTH = 256;
    localparam int W0 = 2;
    localparam int W1 = 0;

    typedef struct {
        int u;
        bit rd;
        bit wr;
        logic [31:0] a;
        logic [31:0] d;
        bit scr;
        bit e_err;
        logic [31:0] e_rd;
        bit c_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic rd_i [2];
    logic wr_i [2];
    logic [31:0] addr_i [2];
    logic [31:0] wdata_i [2];
    logic [31:0] rdata_o [2];
    logic ready_o [2];
    logic busy_o [2];
    logic err_o [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] rd_hold [2];
    bit rd_known [2];
    vec_t tv [$];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd_i[0]), .mem_write(wr_i[0]), .addr(addr_i[0]),
        .wdata(wdata_i[0]), .rdata(rdata_o[0]), .ready(ready_o[0]), .busy(busy_o[0]), .err(err_o[0])
    );
    data_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd_i[1]), .mem_write(wr_i[1]), .addr(addr_i[1]),
        .wdata(wdata_i[1]), .rdata(rdata_o[1]), .ready(ready_o[1]), .busy(busy_o[1]), .err(err_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int u, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit scr, input bit e_err, input logic [31:0] e_rd, input bit c_rd);
        vec_t v;
        v.u = u; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.scr = scr; v.e_err = e_err; v.e_rd = e_rd; v.c_rd = c_rd;
        tv.push_back(v);
    endtask

    task automatic xact(input int u, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scr, input bit e_err, input logic [31:0] e_rd, input bit c_rd, input string tag);
        int n = 0;
        bit busy_ok = 1'b1;
        bit illegal = (rd && wr) || (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        int lat = ((u == 0) ? W0 : W1) + 1;
        rd_i[u] = rd; wr_i[u] = wr; addr_i[u] = a; wdata_i[u] = d;
        @(posedge clk);
        do begin
            @(negedge clk);
            n++;
            if (busy_o[u] !== 1'b1) busy_ok = 1'b0;
            if (scr && ready_o[u] !== 1'b1) begin
                addr_i[u] = $urandom;
                wdata_i[u] = $urandom;
            end
        end while (ready_o[u] !== 1'b1 && n < 20);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, " err"}, {31'b0, err_o[u]}, {31'b0, e_err});
        if (c_rd) chk({tag, " rdata"}, rdata_o[u], e_rd);
        if (wr && !rd && rd_known[u]) chk({tag, " rdata hold"}, rdata_o[u], rd_hold[u]);
        if (!illegal && wr) mem_m[u][a >> 2] = d;
        if (rd && !wr) begin
            rd_hold[u] = illegal ? 32'h0 : mem_m[u][a >> 2];
            rd_known[u] = 1'b1;
        end
        if (rd && wr) rd_known[u] = 1'b0;
        rd_i[u] = 1'b0; wr_i[u] = 1'b0;
        @(negedge clk);
        chk({tag, " ready drop"}, {31'b0, ready_o[u]}, 32'd0);
        chk({tag, " busy drop"}, {31'b0, busy_o[u]}, 32'd0);
    endtask

    initial begin
        bit any_rdy, any_busy, any_err, any_rd;
        for (int u = 0; u < 2; u++) begin
            rd_i[u] = 0; wr_i[u] = 0; addr_i[u] = '0; wdata_i[u] = '0;
            rd_hold[u] = '0; rd_known[u] = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        any_rdy = 0; any_busy = 0; any_err = 0; any_rd = 0;
        repeat (10) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                any_rdy |= (ready_o[u] !== 1'b0);
                any_busy |= (busy_o[u] !== 1'b0);
                any_err |= (err_o[u] !== 1'b0);
                any_rd |= (rdata_o[u] !== 32'h0);
            end
        end
        chk("idle ready", {31'b0, any_rdy}, 32'd0);
        chk("idle busy", {31'b0, any_busy}, 32'd0);
        chk("idle err", {31'b0, any_err}, 32'd0);
        chk("idle rdata", {31'b0, any_rd}, 32'd0);

        add(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        add(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 1);
        add(1, 0, 1, 32'h0, 32'h12345678, 0, 0, 0, 0);
        add(1, 1, 0, 32'h0, 32'h0, 0, 0, 32'h12345678, 1);
        add(0, 0, 1, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0);
        add(0, 1, 0, 32'h6, 32'h0, 0, 1, 32'h0, 1);
        add(0, 0, 1, 32'h400, 32'hBAD0BAD0, 0, 1, 0, 0);
        add(0, 1, 0, 32'h0, 32'h0, 0, 0, 32'hCAFEF00D, 1);
        add(0, 0, 1, 32'h14, 32'h77777777, 0, 0, 0, 0);
        add(0, 1, 1, 32'h14, 32'h99999999, 0, 1, 0, 0);
        add(0, 1, 0, 32'h14, 32'h0, 0, 0, 32'h77777777, 1);
        add(0, 0, 1, 32'h24, 32'h24242424, 0, 0, 0, 0);
        add(0, 0, 1, 32'h20, 32'hA5A5A5A5, 1, 0, 0, 0);
        add(0, 1, 0, 32'h20, 32'h0, 0, 0, 32'hA5A5A5A5, 1);
        add(0, 1, 0, 32'h24, 32'h0, 0, 0, 32'h24242424, 1);
        add(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 1);
        add(0, 0, 1, 32'h40, 32'h11111111, 0, 0, 0, 0);
        add(1, 1, 0, 32'h3, 32'h0, 0, 1, 32'h0, 1);
        add(1, 1, 0, 32'h400, 32'h0, 0, 1, 32'h0, 1);
        foreach (tv[i])
            xact(tv[i].u, tv[i].rd, tv[i].wr, tv[i].a, tv[i].d, tv[i].scr, tv[i].e_err, tv[i].e_rd, tv[i].c_rd,
                 $sformatf("vec%0d", i));

        wr_i[0] = 1'b1; addr_i[0] = 32'h40; wdata_i[0] = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wr_i[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin rd_hold[u] = '0; rd_known[u] = 1'b1; end
        chk("midrst busy", {31'b0, busy_o[0]}, 32'd0);
        chk("midrst rdata", rdata_o[0], 32'h0);
        any_rdy = 0;
        repeat (6) begin
            @(negedge clk);
            any_rdy |= (ready_o[0] !== 1'b0);
        end
        chk("midrst no ready", {31'b0, any_rdy}, 32'd0);
        xact(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h11111111, 1, "midrst load");

        for (int u = 0; u < 2; u++)
            for (int w = 128; w < 136; w++)
                xact(u, 0, 1, 32'(w * 4), $urandom, 0, 0, 0, 0, "rnd init");
        for (int k = 0; k < 40; k++) begin
            int u = $urandom_range(1, 0);
            int w = $urandom_range(135, 128);
            int op = $urandom_range(3, 0);
            case (op)
                0: xact(u, 0, 1, 32'(w * 4), $urandom, 0, 0, 0, 0, $sformatf("rnd%0d st", k));
                1: xact(u, 1, 0, 32'(w * 4), 0, 0, 0, mem_m[u][w], 1, $sformatf("rnd%0d ld", k));
                2: xact(u, 1, 0, 32'(w * 4 + $urandom_range(3, 1)), 0, 0, 1, 32'h0, 1, $sformatf("rnd%0d mis", k));
                default: xact(u, 0, 1, 32'(4 * (DEPTH + $urandom_range(50, 0))), $urandom, 0, 1, 0, 0,
                              $sformatf("rnd%0d oor", k));
            endcase
        end
        for (int u = 0; u < 2; u++)
            for (int w = 128; w < 136; w++)
                xact(u, 1, 0, 32'(w * 4), 0, 0, 0, mem_m[u][w], 1, "rnd final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
